// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: takes symbolic instructions over valid/ready,
// encodes them with the 6-bit opcode map and writes them to consecutive words.
module instr_stream_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [16:0] count,
  output logic        done,
  output logic        err_kind,
  output logic        err_full
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_ACCEPT | in_ready high, waiting for a transfer
  // S_WRITE  | mem_we high for the latched word
  // S_DONE   | one-cycle done pulse
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [16:0] DEPTH_C = 17'(DEPTH);

  logic [1:0]  state;
  logic        last_q;
  logic        legal;
  logic [5:0]  op;
  logic [31:0] enc;
  logic [16:0] count_nxt;

  assign op        = {2'b00, in_kind};
  assign legal     = (in_kind <= 4'd8);
  assign count_nxt = count + 17'd1;

  always_comb begin
    enc = 32'h0;
    case (in_kind)
      4'd0:                         enc = {op, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: enc = {op, in_rs, in_rt, in_imm};
      4'd6, 4'd8:                   enc = {op, in_target};
      4'd7:                         enc = {op, in_rs, 21'b0};
      default:                      enc = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_q    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'h0;
      count     <= 17'd0;
      err_kind  <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ACCEPT;
            mem_addr <= BASE_ADDR;
            count    <= 17'd0;
            err_kind <= 1'b0;
            err_full <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (legal) begin
              mem_wdata <= enc;
              last_q    <= in_last;
              state     <= S_WRITE;
            end else begin
              // illegal kinds are consumed but never written
              err_kind <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          mem_addr <= mem_addr + 32'd4;
          count    <= count_nxt;
          if (last_q) begin
            state <= S_DONE;
          end else if (count_nxt == DEPTH_C) begin
            err_full <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_ACCEPT);
  assign mem_we   = (state == S_WRITE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized self-checking bench for instr_stream_encoder; a program-level
// model predicts writes, counts and error flags for each load.
module tb_instr_stream_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          DEP  = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic        in_ready, mem_we, done, err_kind, err_full;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic [31:0] mem_addr, mem_wdata;
  logic [16:0] count;

  instr_stream_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .done(done),
    .err_kind(err_kind), .err_full(err_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
  } instr_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  instr_t prog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instruction word assembled from field weights
  function automatic logic [31:0] model_enc(input instr_t i);
    int unsigned w;
    w = int'(i.k) * (2 ** 26);
    if (i.k == 0)
      w = w + int'(i.rs) * (2 ** 21) + int'(i.rt) * (2 ** 16) + int'(i.rd) * (2 ** 11)
            + int'(i.sh) * (2 ** 6) + int'(i.fn);
    else if (i.k <= 5)
      w = w + int'(i.rs) * (2 ** 21) + int'(i.rt) * (2 ** 16) + int'(i.imm);
    else if (i.k == 6 || i.k == 8)
      w = w + int'(i.tgt);
    else
      w = w + int'(i.rs) * (2 ** 21);
    return w;
  endfunction

  function automatic instr_t mk(input int k, input int rs, input int rt, input int rd,
                                input int sh, input int fn, input int imm, input int tgt,
                                input int last);
    instr_t i;
    i.k = 4'(k); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.sh = 5'(sh);
    i.fn = 6'(fn); i.imm = 16'(imm); i.tgt = 26'(tgt); i.last = 1'(last);
    return i;
  endfunction

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
    if (mem_we || done) chk("we_done_excl", {31'b0, mem_we & done}, 32'h0);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input instr_t i, input int budget, output bit acc);
    in_kind = i.k; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd; in_shamt = i.sh;
    in_funct = i.fn; in_imm = i.imm; in_target = i.tgt; in_last = i.last;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < budget && !acc; c++) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc && i.k <= 8) chk("we_latency", {31'b0, mem_we}, 32'h1);
  endtask

  task automatic run_prog();
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] a;
    int n_acc, cnt, base_done, w;
    bit ek, ef, fin, acc;
    a = BASE; cnt = 0; ek = 0; ef = 0; fin = 0; n_acc = 0;
    foreach (prog[j]) begin
      if (!fin) begin
        n_acc++;
        if (prog[j].k > 8) ek = 1;
        else begin
          exp_addr.push_back(a);
          exp_data.push_back(model_enc(prog[j]));
          a = a + 4; cnt++;
          if (prog[j].last) fin = 1;
          else if (cnt == DEP) begin ef = 1; fin = 1; end
        end
      end
    end
    got_addr.delete(); got_data.delete();
    base_done = done_cnt;
    pulse_start();
    chk("start_clears_count", {15'b0, count}, 32'h0);
    foreach (prog[j]) begin
      if (j < n_acc) begin
        send(prog[j], 6, acc);
        chk("accepted", {31'b0, acc}, 32'h1);
      end else if (j == n_acc) begin
        send(prog[j], 4, acc);
        chk("refused_after_end", {31'b0, acc}, 32'h0);
      end
    end
    for (int c = 0; c < 10 && done_cnt == base_done; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_pulses", done_cnt - base_done, 32'h1);
    chk("write_count", got_addr.size(), exp_addr.size());
    w = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int j = 0; j < w; j++) begin
      chk("mem_addr", got_addr[j], exp_addr[j]);
      chk("mem_wdata", got_data[j], exp_data[j]);
    end
    chk("count", {15'b0, count}, cnt);
    chk("err_kind", {31'b0, err_kind}, {31'b0, ek});
    chk("err_full", {31'b0, err_full}, {31'b0, ef});
    chk("idle_not_ready", {31'b0, in_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_kind = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0;
    in_imm = '0; in_target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_count", {15'b0, count}, 32'h0);
    chk("rst_flags", {29'b0, done, err_kind, err_full}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    prog.delete();
    prog.push_back(mk(1, 1, 2, 0, 0, 0, 16'h0005, 0, 1));
    run_prog();
    chk("addi_word", got_data[0], 32'h0422_0005);

    prog.delete();
    prog.push_back(mk(0, 3, 4, 5, 0, 6'h20, 0, 0, 0));
    prog.push_back(mk(3, 0, 6, 0, 0, 0, 16'h0010, 0, 0));
    prog.push_back(mk(8, 0, 0, 0, 0, 0, 0, 26'h000040, 1));
    run_prog();
    chk("rtype_word", got_data[0], 32'h0064_2820);
    chk("lw_word", got_data[1], 32'h0C06_0010);
    chk("jal_word", got_data[2], 32'h2000_0040);
    chk("jal_addr", got_addr[2], 32'h0000_0008);

    prog.delete();
    prog.push_back(mk(7, 31, 9, 9, 9, 9, 16'h1234, 26'h3FFFFFF, 0));
    prog.push_back(mk(5, 1, 2, 0, 0, 0, 16'hFFFF, 0, 1));
    run_prog();
    chk("jr_word", got_data[0], 32'h1FE0_0000);
    chk("beq_word", got_data[1], 32'h1422_FFFF);

    prog.delete();
    prog.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0));
    prog.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 1));
    prog.push_back(mk(2, 2, 2, 0, 0, 0, 2, 0, 1));
    run_prog();
    chk("illegal_next_addr", got_addr[1], 32'h0000_0004);
    chk("illegal_count", {15'b0, count}, 32'h2);

    prog.delete();
    for (int j = 0; j < 5; j++) prog.push_back(mk(1, j, j, 0, 0, 0, j, 0, (j == 4) ? 1 : 0));
    run_prog();
    chk("full_writes", got_addr.size(), 32'h4);
    chk("full_flag", {31'b0, err_full}, 32'h1);

    for (int r = 0; r < 30; r++) begin
      instr_t t;
      prog.delete();
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        t = mk(0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
        if ($urandom_range(0, 4) == 0) begin
          t.k = 4'($urandom_range(9, 15));
          t.last = 1'($urandom);
        end else begin
          t.k = 4'($urandom_range(0, 8));
        end
        if (j == n - 1) begin
          t.k = 4'($urandom_range(0, 8));
          t.last = 1'b1;
        end
        prog.push_back(t);
      end
      run_prog();
    end

    // reset during the second word's write strobe
    got_addr.delete(); got_data.delete();
    pulse_start();
    send(mk(1, 1, 2, 0, 0, 0, 7, 0, 0), 6, acc);
    send(mk(2, 3, 4, 0, 0, 0, 8, 0, 0), 6, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", {31'b0, mem_we}, 32'h0);
    chk("abort_ready", {31'b0, in_ready}, 32'h0);
    chk("abort_addr", mem_addr, BASE);
    chk("abort_wdata", mem_wdata, 32'h0);
    chk("abort_count", {15'b0, count}, 32'h0);
    chk("abort_flags", {29'b0, done, err_kind, err_full}, 32'h0);
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_beats_start", {31'b0, in_ready}, 32'h0);
    chk("abort_write_count", got_addr.size(), 32'h2);

    prog.delete();
    prog.push_back(mk(6, 0, 0, 0, 0, 0, 0, 26'h123456, 1));
    run_prog();
    chk("restart_addr", got_addr[0], BASE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
